max7219_tx: RTL and testbench

MAX7219_TX -- requirements
Module: max7219_tx

---
 rtl/max7219_pkg.sv | 49 ++++
 rtl/max7219_tx_frame_shift.sv | 127 ++++++++++++
 rtl/max7219_tx.sv | 140 ++++++++++++++
 tb/tb_max7219_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared constants, controller state type and frame formatting for the MAX7219 serial driver.
// The display is refreshed with 16-bit {4'h0, addr, data} frames.
package max7219_pkg;

    localparam int FRAME_W        = 16;
    localparam int INIT_FRAMES    = 5;
    localparam int REFRESH_FRAMES = 9;

    localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
    localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
    localparam logic [3:0] ADDR_DECODE       = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
    localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

    typedef enum logic [1:0] {
        RESET_INIT,
        IDLE,
        SEND,
        GAP
    } ctrl_state_t;

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

    // Word for position idx of the init (5 frames) or refresh (9 frames) sequence.
    function automatic logic [FRAME_W-1:0] frame_word(input logic        is_init,
                                                      input logic [3:0]  idx,
                                                      input logic [3:0]  intensity,
                                                      input logic [63:0] digits);
        logic [FRAME_W-1:0] w;
        w = mk_frame(ADDR_INTENSITY, {4'h0, intensity});
        if (is_init) begin
            case (idx)
                4'd0:    w = mk_frame(ADDR_DISPLAY_TEST, 8'h00);
                4'd1:    w = mk_frame(ADDR_SCAN_LIMIT, 8'h07);
                4'd2:    w = mk_frame(ADDR_DECODE, 8'hFF);
                4'd3:    w = mk_frame(ADDR_INTENSITY, {4'h0, intensity});
                default: w = mk_frame(ADDR_SHUTDOWN, 8'h01);
            endcase
        end else if (idx != 4'd0 && (ADDR_DIGIT0 + idx - 4'd1) <= ADDR_DIGIT7) begin
            w = mk_frame(ADDR_DIGIT0 + idx - 4'd1, digits[(int'(idx) - 1) * 8 +: 8]);
        end
        return w;
    endfunction

endpackage

// File: rtl/max7219_tx_frame_shift.sv
// Serialises one 16-bit frame onto din/clk/load: 16 bit slots, a din=0 tail, then a load-high gap.
// A new start is accepted while idle or in the very last gap cycle, so frames can run back to back.
module max7219_frame_shift
    import max7219_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_word,
    output logic               o_din,
    output logic               o_sclk,
    output logic               o_load,
    output logic               o_hold,
    output logic               o_done
);

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_BITS,
        PH_TAIL,
        PH_HOLD
    } phase_t;

    localparam logic [8:0] HALF_TC = 9'(CLK_DIV - 1);
    localparam logic [8:0] HOLD_TC = 9'(2 * CLK_DIV - 1);

    phase_t             phase_q, phase_d;
    logic [3:0]         bit_q, bit_d;
    logic               half_q, half_d;
    logic [8:0]         div_q, div_d;
    logic [FRAME_W-1:0] word_q, word_d;
    logic               din_q, din_d;
    logic               sclk_q, sclk_d;
    logic               load_q, load_d;
    logic               div_tc;
    logic               can_start;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_q <= PH_IDLE;
            bit_q   <= '0;
            half_q  <= 1'b0;
            div_q   <= '0;
            word_q  <= '0;
            din_q   <= 1'b0;
            sclk_q  <= 1'b0;
            load_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            div_q   <= div_d;
            word_q  <= word_d;
            din_q   <= din_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        half_d  = half_q;
        div_d   = div_q;
        word_d  = word_q;
        o_done  = 1'b0;
        div_tc  = (div_q == 9'd0);

        case (phase_q)
            PH_BITS: begin
                if (!div_tc) begin
                    div_d = div_q - 9'd1;
                end else if (!half_q) begin
                    half_d = 1'b1;
                    div_d  = HALF_TC;
                end else if (bit_q == 4'd0) begin
                    phase_d = PH_TAIL;
                    half_d  = 1'b0;
                    div_d   = HALF_TC;
                end else begin
                    bit_d  = bit_q - 4'd1;
                    half_d = 1'b0;
                    div_d  = HALF_TC;
                end
            end
            PH_TAIL: begin
                if (!div_tc) begin
                    div_d = div_q - 9'd1;
                end else begin
                    phase_d = PH_HOLD;
                    div_d   = HOLD_TC;
                end
            end
            PH_HOLD: begin
                if (!div_tc) begin
                    div_d = div_q - 9'd1;
                end else begin
                    phase_d = PH_IDLE;
                    o_done  = 1'b1;
                end
            end
            default: ;
        endcase

        can_start = (phase_q == PH_IDLE) || (phase_q == PH_HOLD && div_tc);
        if (i_start && can_start) begin
            phase_d = PH_BITS;
            bit_d   = 4'd15;
            half_d  = 1'b0;
            div_d   = HALF_TC;
            word_d  = i_word;
        end

        // Outputs are registered from the next state so the pins never glitch.
        din_d  = (phase_d == PH_BITS) ? word_d[bit_d] : 1'b0;
        sclk_d = (phase_d == PH_BITS) && half_d;
        load_d = !((phase_d == PH_BITS) || (phase_d == PH_TAIL));
    end

    assign o_din  = din_q;
    assign o_sclk = sclk_q;
    assign o_load = load_q;
    assign o_hold = (phase_q == PH_HOLD);

endmodule

// File: rtl/max7219_tx.sv
// MAX7219 sequencer: sends the init sequence after reset, then 9-frame refreshes on request.
// Requests arriving while busy collapse into one pending refresh that starts back to back.
module max7219_tx
    import max7219_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_write,
    input  logic [3:0]  i_intensity,
    input  logic [63:0] i_digits,
    output logic        o_busy,
    output logic        o_serial_din,
    output logic        o_serial_load,
    output logic        o_serial_clk
);

    ctrl_state_t        state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic               init_q, init_d;
    logic               pending_q, pending_d;
    logic [3:0]         snap_int_q, snap_int_d;
    logic [63:0]        snap_dig_q, snap_dig_d;
    logic               busy_q, busy_d;
    logic               start;
    logic               new_snap;
    logic [3:0]         last_idx;
    logic [3:0]         cur_int;
    logic [63:0]        cur_dig;
    logic [FRAME_W-1:0] word;
    logic               fs_hold;
    logic               fs_done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= RESET_INIT;
            idx_q      <= '0;
            init_q     <= 1'b1;
            pending_q  <= 1'b0;
            snap_int_q <= '0;
            snap_dig_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            init_q     <= init_d;
            pending_q  <= pending_d;
            snap_int_q <= snap_int_d;
            snap_dig_q <= snap_dig_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        init_d     = init_q;
        pending_d  = pending_q;
        snap_int_d = snap_int_q;
        snap_dig_d = snap_dig_q;
        start      = 1'b0;
        new_snap   = 1'b0;
        last_idx   = init_q ? 4'(INIT_FRAMES - 1) : 4'(REFRESH_FRAMES - 1);

        if (i_write && state_q != IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            RESET_INIT: begin
                new_snap = 1'b1;
                init_d   = 1'b1;
                idx_d    = 4'd0;
                start    = 1'b1;
                state_d  = SEND;
            end
            IDLE: begin
                if (i_write) begin
                    new_snap = 1'b1;
                    init_d   = 1'b0;
                    idx_d    = 4'd0;
                    start    = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (fs_hold) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (fs_done) begin
                    if (idx_q != last_idx) begin
                        idx_d   = idx_q + 4'd1;
                        start   = 1'b1;
                        state_d = SEND;
                    end else if (pending_q || i_write) begin
                        // A request landing on the final cycle is served like a pending one.
                        pending_d = 1'b0;
                        new_snap  = 1'b1;
                        init_d    = 1'b0;
                        idx_d     = 4'd0;
                        start     = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = RESET_INIT;
        endcase

        if (new_snap) begin
            snap_int_d = i_intensity;
            snap_dig_d = i_digits;
        end
        cur_int = new_snap ? i_intensity : snap_int_q;
        cur_dig = new_snap ? i_digits : snap_dig_q;
        word    = frame_word(init_d, idx_d, cur_int, cur_dig);
        busy_d  = (state_d != IDLE) || pending_d;
    end

    max7219_frame_shift #(
        .CLK_DIV(CLK_DIV)
    ) u_frame_shift (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_start(start),
        .i_word (word),
        .o_din  (o_serial_din),
        .o_sclk (o_serial_clk),
        .o_load (o_serial_load),
        .o_hold (fs_hold),
        .o_done (fs_done)
    );

    assign o_busy = busy_q;

endmodule

// File: tb/tb_max7219_tx.sv
// Two instances (CLK_DIV=2 and CLK_DIV=1) share randomized stimulus; each has a MAX7219 receiver,
// a protocol checker and a frame-level reference model feeding a scoreboard queue.
module tb_max7219_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [3:0]  inten = 4'h0;
    logic [63:0] digs = '0;
    logic [1:0]  busy, din, sclk, load;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] exp0[$];
    logic [15:0] exp1[$];

    int          m_end[2];
    bit          m_pend[2];
    bit          m_first[2];
    bit          m_busy[2];
    logic [15:0] sh[2];
    int          nbits[2];
    int          lowcnt[2];
    logic        p_din[2];
    logic        p_sclk[2];
    logic        p_load[2];
    logic [7:0]  disp0[8];

    int req_seq = 0;
    int ack_seq = 0;
    int req_kind = 0;

    initial forever #5 clk = ~clk;

    max7219_tx #(.CLK_DIV(2)) u_dut_div2 (
        .i_clk(clk), .i_reset(rst), .i_write(wr), .i_intensity(inten), .i_digits(digs),
        .o_busy(busy[0]), .o_serial_din(din[0]), .o_serial_load(load[0]), .o_serial_clk(sclk[0]));

    max7219_tx #(.CLK_DIV(1)) u_dut_div1 (
        .i_clk(clk), .i_reset(rst), .i_write(wr), .i_intensity(inten), .i_digits(digs),
        .o_busy(busy[1]), .o_serial_din(din[1]), .o_serial_load(load[1]), .o_serial_clk(sclk[1]));

    function automatic int div_of(int g);
        return (g == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic void push_exp(int g, logic [15:0] w);
        if (g == 0) exp0.push_back(w);
        else exp1.push_back(w);
    endfunction

    function automatic int exp_size(int g);
        return (g == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic logic [15:0] pop_exp(int g);
        return (g == 0) ? exp0.pop_front() : exp1.pop_front();
    endfunction

    function automatic void clear_exp(int g);
        if (g == 0) exp0.delete();
        else exp1.delete();
    endfunction

    function automatic void push_init(int g, logic [3:0] i);
        push_exp(g, 16'h0F00);
        push_exp(g, 16'h0B07);
        push_exp(g, 16'h09FF);
        push_exp(g, {12'h0A0, i});
        push_exp(g, 16'h0C01);
    endfunction

    function automatic void push_refresh(int g, logic [3:0] i, logic [63:0] d);
        push_exp(g, {12'h0A0, i});
        for (int k = 0; k < 8; k++) push_exp(g, {4'h0, 4'(k + 1), d[8*k +: 8]});
    endfunction

    // Monitor, receiver, protocol checker and reference model; sampled on the falling edge.
    initial begin
        for (int g = 0; g < 2; g++) begin
            m_end[g] = 0; m_pend[g] = 0; m_first[g] = 1; m_busy[g] = 1;
            sh[g] = '0; nbits[g] = 0; lowcnt[g] = 0;
            p_din[g] = 0; p_sclk[g] = 0; p_load[g] = 1;
        end
        for (int k = 0; k < 8; k++) disp0[k] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                int d;
                d = div_of(g);
                if (rst) begin
                    check("reset_load", 32'(load[g]), 1);
                    check("reset_sclk", 32'(sclk[g]), 0);
                    check("reset_din", 32'(din[g]), 0);
                    check("reset_busy", 32'(busy[g]), 1);
                end else begin
                    check("busy", 32'(busy[g]), 32'(m_busy[g]));
                end
                if (!load[g]) begin
                    if (p_load[g]) begin
                        lowcnt[g] = 1;
                        nbits[g] = 0;
                    end else begin
                        lowcnt[g] = lowcnt[g] + 1;
                    end
                end
                if (!p_sclk[g] && sclk[g]) begin
                    check("din_stable_at_sclk_rise", 32'(din[g]), 32'(p_din[g]));
                    sh[g] = {sh[g][14:0], din[g]};
                    nbits[g] = nbits[g] + 1;
                end
                if (!p_load[g] && load[g] && !rst) begin
                    logic [15:0] w;
                    check("load_rise_sclk_low", 32'(sclk[g] | p_sclk[g]), 0);
                    check("frame_bits", nbits[g], 16);
                    check("load_low_cycles", lowcnt[g], 33 * d);
                    if (exp_size(g) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame dut%0d: got %0h expected none", g, sh[g]);
                    end else begin
                        w = pop_exp(g);
                        check(g == 0 ? "frame_div2" : "frame_div1", 32'(sh[g]), 32'(w));
                    end
                    if (g == 0 && sh[g][11:8] >= 4'h1 && sh[g][11:8] <= 4'h8)
                        disp0[sh[g][11:8] - 4'h1] = sh[g][7:0];
                end
                p_din[g] = din[g];
                p_sclk[g] = sclk[g];
                p_load[g] = load[g];

                // Reference model for the coming edge: sequences take frames*35*d cycles.
                begin
                    int e;
                    int f;
                    e = cyc + 1;
                    f = 35 * d;
                    if (rst) begin
                        clear_exp(g);
                        m_first[g] = 1;
                        m_pend[g] = 0;
                        m_busy[g] = 1;
                    end else if (m_first[g]) begin
                        m_first[g] = 0;
                        push_init(g, inten);
                        m_end[g] = e + 5 * f;
                        m_pend[g] = wr;
                        m_busy[g] = 1;
                    end else begin
                        if (e == m_end[g]) begin
                            if (m_pend[g] || wr) begin
                                push_refresh(g, inten, digs);
                                m_end[g] = e + 9 * f;
                                m_pend[g] = 0;
                            end
                        end else if (e < m_end[g]) begin
                            if (wr) m_pend[g] = 1;
                        end else if (wr) begin
                            push_refresh(g, inten, digs);
                            m_end[g] = e + 9 * f;
                        end
                        m_busy[g] = (e < m_end[g]) || m_pend[g];
                    end
                end
            end
            if (req_seq != ack_seq) begin
                case (req_kind)
                    1: check("digit7_with_dp", 32'(disp0[7]), 32'h87);
                    2: begin
                        checks++;
                        errors++;
                        $display("FAIL wait_timeout: busy=%0b still high, required idle", busy);
                    end
                    default: begin
                        check("leftover_frames_div2", exp_size(0), 0);
                        check("leftover_frames_div1", exp_size(1), 0);
                    end
                endcase
                ack_seq = req_seq;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_write();
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic request(input int kind);
        req_kind = kind;
        req_seq++;
        for (int i = 0; i < 8 && ack_seq != req_seq; i++) tick();
    endtask

    task automatic wait_idle(input int budget, input bit scramble);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy == 2'b00) begin
                ok = 1;
                break;
            end
            if (scramble) begin
                inten = 4'($urandom);
                digs = {$urandom, $urandom};
            end
            tick();
        end
        if (!ok) request(2);
    endtask

    initial begin
        inten = 4'($urandom);
        digs = {$urandom, $urandom};
        repeat (3) tick();
        rst = 1'b0;
        wait_idle(1000, 0);

        // Known pattern with decimal point on digit 7.
        inten = 4'h7;
        digs = 64'h8706050403020100;
        tick();
        pulse_write();
        wait_idle(1000, 0);
        request(1);

        // Three requests during a refresh, inputs scrambled every cycle.
        inten = 4'($urandom);
        digs = {$urandom, $urandom};
        pulse_write();
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(10, 120)) begin
                inten = 4'($urandom);
                digs = {$urandom, $urandom};
                tick();
            end
            pulse_write();
        end
        wait_idle(2000, 1);

        // Digits change in the cycle right after the request.
        inten = 4'($urandom);
        digs = {$urandom, $urandom};
        pulse_write();
        digs = {$urandom, $urandom};
        inten = 4'($urandom);
        wait_idle(1000, 0);

        // Random request spacing, including back-to-back and idle starts.
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 700)) begin
                inten = 4'($urandom);
                digs = {$urandom, $urandom};
                tick();
            end
            pulse_write();
        end
        wait_idle(3000, 1);

        // Request during the init sequence.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (7) tick();
        pulse_write();
        wait_idle(3000, 0);

        // Reset in the middle of a frame, at bit 6.
        pulse_write();
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 400; i++) begin
                if (nbits[0] == 6 && !load[0]) begin
                    hit = 1;
                    break;
                end
                tick();
            end
            if (!hit) request(2);
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_idle(1000, 0);
        repeat (5) tick();

        request(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
